// File: rtl/gen_fifo_rd_ctrl.sv
// Read-side pointer and status controller for an asynchronous FIFO.
// It synchronizes the foreign write pointer and registers the level, flags, gray pointer and read-valid.

module gen_gray2binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // Each binary bit is the XOR of its own gray bit and every gray bit above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

module gen_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH    = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_async,
    input  logic                  rd_en,
    input  logic                  rd_flush,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow,
    output logic                  ptr_err
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P   = PW'(1 << ADDR_WIDTH);
    localparam logic [PW-1:0] AEMPTY_P  = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wptr_gray_meta_p0;
    logic [PW-1:0] wptr_gray_sync;
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] next_rd_ptr_bin;
    logic [PW-1:0] next_level;
    logic          pop_ok;
    logic          pop_reject;

    // Stage boundary: two-flop synchronizer for the foreign write pointer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wptr_gray_meta_p0 <= '0;
            wptr_gray_sync    <= '0;
        end else begin
            wptr_gray_meta_p0 <= wr_ptr_gray_async;
            wptr_gray_sync    <= wptr_gray_meta_p0;
        end
    end

    gen_gray2binary #(.WIDTH(PW)) u_wptr_g2b (
        .gray (wptr_gray_sync),
        .bin  (wptr_bin)
    );

    always_comb begin
        pop_ok          = rd_en && !empty && !rd_flush;
        pop_reject      = rd_en && empty && !rd_flush;
        next_rd_ptr_bin = rd_ptr_bin;
        if (rd_flush) begin
            next_rd_ptr_bin = wptr_bin;
        end else if (pop_ok) begin
            next_rd_ptr_bin = rd_ptr_bin + PW'(1);
        end
        next_level = wptr_bin - next_rd_ptr_bin;
    end

    // Stage boundary: pointer and status registers, all derived from the post-edge pointer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rd_ptr_bin   <= '0;
            rd_ptr_gray  <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
            rd_level     <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            ptr_err      <= 1'b0;
        end else begin
            rd_ptr_bin   <= next_rd_ptr_bin;
            rd_ptr_gray  <= next_rd_ptr_bin ^ (next_rd_ptr_bin >> 1);
            rd_valid     <= pop_ok;
            underflow    <= pop_reject;
            rd_level     <= next_level;
            empty        <= (next_level == '0);
            almost_empty <= (next_level <= AEMPTY_P);
            if (next_level > DEPTH_P) begin
                ptr_err <= 1'b1;
            end
        end
    end

    assign rd_addr = rd_ptr_bin[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_gen_fifo_rd_ctrl.sv
// Directed self-checking bench for gen_fifo_rd_ctrl with ADDR_WIDTH=3, AEMPTY_THRESH=1.

module tb_gen_fifo_rd_ctrl;
    logic       hclk;
    logic       hresetn;
    logic [3:0] wr_ptr_gray_async;
    logic       rd_en;
    logic       rd_flush;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr_gray;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       underflow;
    logic       ptr_err;

    int checks;
    int failures;

    gen_fifo_rd_ctrl #(.ADDR_WIDTH(3), .AEMPTY_THRESH(1)) dut (
        .hclk              (hclk),
        .hresetn           (hresetn),
        .wr_ptr_gray_async (wr_ptr_gray_async),
        .rd_en             (rd_en),
        .rd_flush          (rd_flush),
        .rd_addr           (rd_addr),
        .rd_ptr_gray       (rd_ptr_gray),
        .rd_valid          (rd_valid),
        .empty             (empty),
        .almost_empty      (almost_empty),
        .rd_level          (rd_level),
        .underflow         (underflow),
        .ptr_err           (ptr_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        wr_ptr_gray_async = 4'b0000;
        rd_en = 1'b0;
        rd_flush = 1'b0;
        #12;
        @(negedge hclk);
        hresetn = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        @(negedge hclk);
        rd_en = 1'b0;
        rd_flush = 1'b0;
        wr_ptr_gray_async = 4'b0111;
        step(3);
        #2;
        hresetn = 1'b0;
        #1;
        checks++; if (rd_addr !== 3'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", rd_addr); end
        checks++; if (rd_ptr_gray !== 4'b0000) begin failures++; $display("FAIL rst_gray got=%b exp=0000", rd_ptr_gray); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL rst_aempty got=%b exp=1", almost_empty); end
        checks++; if (rd_level !== 4'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", rd_level); end
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("FAIL rst_ptr_err got=%b exp=0", ptr_err); end
        wr_ptr_gray_async = 4'b0000;
        @(negedge hclk);
        hresetn = 1'b1;
        step(1);
    endtask

    task automatic test_fill_and_pop();
        do_reset();
        wr_ptr_gray_async = 4'b0111;
        step(2);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_lat2_empty got=%b exp=1", empty); end
        step(1);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", empty); end
        checks++; if (rd_level !== 4'd5) begin failures++; $display("FAIL fill_level got=%0d exp=5", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL fill_aempty got=%b exp=0", almost_empty); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL pop_valid_pre got=%b exp=0", rd_valid); end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rd_addr !== 3'(i)) begin failures++; $display("FAIL pop_addr%0d got=%0d exp=%0d", i, rd_addr, i); end
            step(1);
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL pop_valid%0d got=%b exp=1", i, rd_valid); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pop_empty got=%b exp=1", empty); end
        checks++; if (rd_ptr_gray !== 4'b0111) begin failures++; $display("FAIL pop_gray got=%b exp=0111", rd_ptr_gray); end
        step(1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL pop_valid_post got=%b exp=0", rd_valid); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_pulse got=%b exp=1", underflow); end
        checks++; if (rd_ptr_gray !== 4'b0111) begin failures++; $display("FAIL uf_gray got=%b exp=0111", rd_ptr_gray); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL uf_valid got=%b exp=0", rd_valid); end
        step(1);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_addr [4];
        exp_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
        do_reset();
        wr_ptr_gray_async = 4'b0100;
        step(3);
        rd_flush = 1'b1;
        step(1);
        rd_flush = 1'b0;
        wr_ptr_gray_async = 4'b1001;
        step(3);
        rd_flush = 1'b1;
        step(1);
        rd_flush = 1'b0;
        checks++; if (rd_ptr_gray !== 4'b1001) begin failures++; $display("FAIL wrap_start_gray got=%b exp=1001", rd_ptr_gray); end
        wr_ptr_gray_async = 4'b0011;
        step(3);
        checks++; if (rd_level !== 4'd4) begin failures++; $display("FAIL wrap_level got=%0d exp=4", rd_level); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_addr !== exp_addr[i]) begin failures++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, rd_addr, exp_addr[i]); end
            step(1);
        end
        rd_en = 1'b0;
        checks++; if (rd_addr !== 3'd2) begin failures++; $display("FAIL wrap_end_addr got=%0d exp=2", rd_addr); end
        checks++; if (rd_ptr_gray !== 4'b0011) begin failures++; $display("FAIL wrap_end_gray got=%b exp=0011", rd_ptr_gray); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("FAIL wrap_ptr_err got=%b exp=0", ptr_err); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wr_ptr_gray_async = 4'b0011;
        step(3);
        checks++; if (rd_level !== 4'd2) begin failures++; $display("FAIL sim_level0 got=%0d exp=2", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL sim_aempty0 got=%b exp=0", almost_empty); end
        wr_ptr_gray_async = 4'b0010;
        step(1);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        checks++; if (rd_level !== 4'd1) begin failures++; $display("FAIL sim_level1 got=%0d exp=1", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL sim_aempty1 got=%b exp=1", almost_empty); end
        step(1);
        checks++; if (rd_level !== 4'd2) begin failures++; $display("FAIL sim_level2 got=%0d exp=2", rd_level); end
    endtask

    task automatic test_flush_and_ptr_err();
        do_reset();
        wr_ptr_gray_async = 4'b0010;
        step(3);
        checks++; if (rd_level !== 4'd3) begin failures++; $display("FAIL fl_level_pre got=%0d exp=3", rd_level); end
        rd_en = 1'b1;
        rd_flush = 1'b1;
        step(1);
        rd_en = 1'b0;
        rd_flush = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fl_empty got=%b exp=1", empty); end
        checks++; if (rd_level !== 4'd0) begin failures++; $display("FAIL fl_level got=%0d exp=0", rd_level); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", rd_valid); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL fl_underflow got=%b exp=0", underflow); end
        checks++; if (rd_ptr_gray !== 4'b0010) begin failures++; $display("FAIL fl_gray got=%b exp=0010", rd_ptr_gray); end
        wr_ptr_gray_async = 4'b1010;
        step(2);
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("FAIL perr_early got=%b exp=0", ptr_err); end
        step(1);
        checks++; if (rd_level !== 4'd9) begin failures++; $display("FAIL perr_level got=%0d exp=9", rd_level); end
        checks++; if (ptr_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", ptr_err); end
        wr_ptr_gray_async = 4'b0111;
        step(5);
        checks++; if (ptr_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", ptr_err); end
    endtask

    task automatic test_reset_mid_pop();
        do_reset();
        wr_ptr_gray_async = 4'b0111;
        step(3);
        rd_en = 1'b1;
        #2;
        hresetn = 1'b0;
        #1;
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rmp_valid got=%b exp=0", rd_valid); end
        @(negedge hclk);
        hresetn = 1'b1;
        step(1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rmp_valid_post got=%b exp=0", rd_valid); end
        checks++; if (rd_addr !== 3'd0) begin failures++; $display("FAIL rmp_addr got=%0d exp=0", rd_addr); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        hresetn = 1'b0;
        wr_ptr_gray_async = 4'b0000;
        rd_en = 1'b0;
        rd_flush = 1'b0;
        #17;
        hresetn = 1'b1;
        test_reset();
        test_fill_and_pop();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_flush_and_ptr_err();
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
